// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// handshake, writes the IF/ID register and parks on HLT.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [3:0]  HALT_OP   = 4'hF,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] PC_out_to_IFID,
  output logic [15:0] imem_data_out_to_IFID,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] fetch_wait_cnt
);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n, pc_plus2;
  logic [15:0] pcout_n, data_n, cnt_n;
  logic        valid_n, halted_n;
  logic        xfer;

  assign pc_plus2  = pc + 16'd2;
  assign imem_addr = pc;
  assign imem_req  = (state == FETCH) & ~stall_in & ~branch_taken & rst;
  assign xfer      = imem_req & imem_ready;

  // State, PC and IF/ID register update; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state                 <= FETCH;
      pc                    <= RESET_PC;
      PC_out_to_IFID        <= '0;
      imem_data_out_to_IFID <= NOP_INSTR;
      ifid_valid            <= 1'b0;
      halted                <= 1'b0;
      fetch_wait_cnt        <= '0;
    end else begin
      state                 <= state_n;
      pc                    <= pc_n;
      PC_out_to_IFID        <= pcout_n;
      imem_data_out_to_IFID <= data_n;
      ifid_valid            <= valid_n;
      halted                <= halted_n;
      fetch_wait_cnt        <= cnt_n;
    end
  end

  // Next-state logic: redirect, then halted bubble, then stall hold, then fetch.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    pcout_n  = PC_out_to_IFID;
    data_n   = imem_data_out_to_IFID;
    valid_n  = ifid_valid;
    halted_n = halted;
    cnt_n    = fetch_wait_cnt;

    if (branch_taken) begin
      state_n  = FETCH;
      pc_n     = branch_target;
      halted_n = 1'b0;
      data_n   = NOP_INSTR;
      valid_n  = 1'b0;
    end else if (state == HALTED) begin
      data_n  = NOP_INSTR;
      valid_n = 1'b0;
    end else if (stall_in) begin
      // hold everything
    end else if (xfer) begin
      pcout_n = pc_plus2;
      data_n  = imem_data;
      valid_n = 1'b1;
      if (imem_data[15:12] == HALT_OP) begin
        state_n  = HALTED;
        halted_n = 1'b1;
      end else begin
        pc_n = pc_plus2;
      end
    end else begin
      data_n  = NOP_INSTR;
      valid_n = 1'b0;
      if (fetch_wait_cnt != '1) cnt_n = fetch_wait_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural fetch model plus a
// memory with configurable wait states, driven per cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall_in, branch_taken, imem_ready;
  logic [15:0] branch_target, imem_data;
  logic        imem_req, ifid_valid, halted;
  logic [15:0] imem_addr, PC_out_to_IFID, imem_data_out_to_IFID, fetch_wait_cnt;

  fetch_unit #(.RESET_PC(16'h0000), .HALT_OP(4'hF), .NOP_INSTR(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .PC_out_to_IFID(PC_out_to_IFID),
    .imem_data_out_to_IFID(imem_data_out_to_IFID), .ifid_valid(ifid_valid),
    .halted(halted), .fetch_wait_cnt(fetch_wait_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // memory image: explicit words, otherwise a non-HLT pattern derived from the address
  logic [15:0] mem [logic [15:0]];
  int unsigned waits = 0;
  int unsigned wait_left = 0;
  bit          rand_waits = 0;

  // reference model of the fetch stage
  logic [15:0] m_pc = 0, m_pcout = 0, m_data = 0, m_cnt = 0;
  logic        m_valid = 0, m_halt = 0;

  // observations of the latest step
  logic        obs_req, exp_req;
  logic [15:0] obs_addr, exp_addr;
  logic [49:0] obs_out, exp_out;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return {1'b0, a[14:0] ^ 15'h2B5D};
  endfunction

  function automatic int unsigned new_wait();
    return rand_waits ? $urandom_range(0, 3) : waits;
  endfunction

  // one clock: drive inputs at negedge, answer as memory, advance model, sample after posedge
  task automatic step(input logic st, input logic br, input logic [15:0] tgt, input logic rs);
    logic        ereq, rdy;
    logic [15:0] d;
    stall_in = st; branch_taken = br; branch_target = tgt; rst = rs;
    ereq = !m_halt && !st && !br && rs;
    if (ereq && wait_left == 0) begin
      rdy = 1'b1; d = mem_word(m_pc);
    end else begin
      rdy = ereq ? 1'b0 : 1'($urandom % 2); d = 16'($urandom);
    end
    imem_ready = rdy; imem_data = d;
    #1;
    obs_req = imem_req; obs_addr = imem_addr;
    exp_req = ereq;     exp_addr = m_pc;

    if (!rs) begin
      m_pc = 16'h0000; m_halt = 0; m_pcout = 0; m_data = 16'h0000; m_valid = 0; m_cnt = 0;
    end else if (br) begin
      m_pc = tgt; m_halt = 0; m_data = 16'h0000; m_valid = 0;
    end else if (m_halt) begin
      m_data = 16'h0000; m_valid = 0;
    end else if (!st) begin
      if (rdy) begin
        m_pcout = m_pc + 16'd2; m_data = d; m_valid = 1;
        if (d[15:12] == 4'hF) m_halt = 1;
        else m_pc = m_pc + 16'd2;
      end else begin
        m_data = 16'h0000; m_valid = 0;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end

    if (ereq && !rdy) wait_left = wait_left - 1;
    else wait_left = new_wait();

    @(posedge clk); #1;
    obs_out = {PC_out_to_IFID, imem_data_out_to_IFID, ifid_valid, halted, fetch_wait_cnt};
    exp_out = {m_pcout, m_data, m_valid, m_halt, m_cnt};
    @(negedge clk);
  endtask

  task automatic set_waits(input int unsigned w);
    waits = w; wait_left = w; rand_waits = 0;
  endtask

  task automatic test_reset();
    set_waits(0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (obs_out !== 50'h0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d actual=%h required=%h", i, obs_out, 50'h0);
      end
    end
    checks++;
    if (imem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_pc actual=%h required=%h", imem_addr, 16'h0000);
    end
  endtask

  task automatic test_straight();
    mem.delete();
    mem[16'h0000] = 16'h1234; mem[16'h0002] = 16'h2345;
    set_waits(0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      checks++;
      if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
        failures++;
        $display("FAIL straight_req_addr cycle=%0d actual=%h required=%h", i, {obs_req, obs_addr}, {exp_req, exp_addr});
      end
      checks++;
      if (obs_out !== exp_out) begin
        failures++;
        $display("FAIL straight_ifid cycle=%0d actual=%h required=%h", i, obs_out, exp_out);
      end
    end
    checks++;
    if ({PC_out_to_IFID, imem_data_out_to_IFID} !== {16'h0006, mem_word(16'h0004)}) begin
      failures++;
      $display("FAIL straight_third actual=%h required=%h", {PC_out_to_IFID, imem_data_out_to_IFID}, {16'h0006, mem_word(16'h0004)});
    end
  endtask

  task automatic test_wait_states();
    mem.delete();
    step(1'b0, 1'b0, 16'h0, 1'b0);
    set_waits(3);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      checks++;
      if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
        failures++;
        $display("FAIL wait_req_addr cycle=%0d actual=%h required=%h", i, {obs_req, obs_addr}, {exp_req, exp_addr});
      end
      checks++;
      if (obs_out !== exp_out) begin
        failures++;
        $display("FAIL wait_ifid cycle=%0d actual=%h required=%h", i, obs_out, exp_out);
      end
    end
    checks++;
    if (fetch_wait_cnt !== 16'd6) begin
      failures++;
      $display("FAIL wait_count actual=%0d required=%0d", fetch_wait_cnt, 6);
    end
  endtask

  task automatic test_stall();
    logic st;
    mem.delete();
    set_waits(0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      st = (i == 4 || i == 5);
      step(st, 1'b0, 16'h0, 1'b1);
      checks++;
      if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
        failures++;
        $display("FAIL stall_req_addr cycle=%0d actual=%h required=%h", i, {obs_req, obs_addr}, {exp_req, exp_addr});
      end
      checks++;
      if (obs_out !== exp_out) begin
        failures++;
        $display("FAIL stall_ifid cycle=%0d actual=%h required=%h", i, obs_out, exp_out);
      end
    end
  endtask

  task automatic test_branch_cancel();
    mem.delete();
    set_waits(0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    set_waits(3);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'h0040, 1'b1);
    checks++;
    if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
      failures++;
      $display("FAIL branch_req actual=%h required=%h", {obs_req, obs_addr}, {exp_req, exp_addr});
    end
    checks++;
    if ({imem_addr, ifid_valid} !== {16'h0040, 1'b0} || obs_out !== exp_out) begin
      failures++;
      $display("FAIL branch_redirect actual=%h/%h required=%h/%h", imem_addr, obs_out, 16'h0040, exp_out);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1);
      checks++;
      if (obs_out !== exp_out || (ifid_valid && PC_out_to_IFID == 16'h0008)) begin
        failures++;
        $display("FAIL branch_after cycle=%0d actual=%h required=%h", i, obs_out, exp_out);
      end
    end
  endtask

  task automatic test_halt();
    mem.delete();
    mem[16'h000A] = 16'hF000;
    set_waits(0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      if (i == 11) step(1'b0, 1'b1, 16'h0020, 1'b1);
      else step(1'($urandom % 2) & (i > 6 && i < 11), 1'b0, 16'h0, 1'b1);
      checks++;
      if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
        failures++;
        $display("FAIL halt_req_addr cycle=%0d actual=%h required=%h", i, {obs_req, obs_addr}, {exp_req, exp_addr});
      end
      checks++;
      if (obs_out !== exp_out) begin
        failures++;
        $display("FAIL halt_ifid cycle=%0d actual=%h required=%h", i, obs_out, exp_out);
      end
      if (i == 5) begin
        checks++;
        if ({PC_out_to_IFID, imem_data_out_to_IFID, ifid_valid, halted} !== {16'h000C, 16'hF000, 1'b1, 1'b1}) begin
          failures++;
          $display("FAIL halt_entry actual=%h required=%h", {PC_out_to_IFID, imem_data_out_to_IFID, ifid_valid, halted}, {16'h000C, 16'hF000, 1'b1, 1'b1});
        end
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    mem.delete();
    set_waits(0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'hFFFE, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    checks++;
    if ({PC_out_to_IFID, imem_addr, ifid_valid} !== {16'h0000, 16'h0000, 1'b1} || obs_out !== exp_out) begin
      failures++;
      $display("FAIL wrap actual=%h/%h required=%h/%h", PC_out_to_IFID, imem_addr, 16'h0000, exp_out);
    end
    set_waits(3);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if ({imem_addr, fetch_wait_cnt, ifid_valid, halted} !== {16'h0000, 16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_wait actual=%h required=%h", {imem_addr, fetch_wait_cnt, ifid_valid, halted}, 34'h0);
    end
  endtask

  task automatic test_random();
    mem.delete();
    mem[16'h0030] = 16'hF123; mem[16'h007A] = 16'hFABC; mem[16'h0011] = 16'hF000;
    step(1'b0, 1'b0, 16'h0, 1'b0);
    waits = 0; wait_left = 0; rand_waits = 1;
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 5) == 0, ($urandom % 12) == 0, 16'($urandom_range(0, 255)), ($urandom % 60) != 0);
      checks++;
      if ({obs_req, obs_addr} !== {exp_req, exp_addr}) begin
        failures++;
        $display("FAIL random_req_addr cycle=%0d actual=%h required=%h", i, {obs_req, obs_addr}, {exp_req, exp_addr});
      end
      checks++;
      if (obs_out !== exp_out) begin
        failures++;
        $display("FAIL random_ifid cycle=%0d actual=%h required=%h", i, obs_out, exp_out);
      end
    end
  endtask

  initial begin
    rst = 1'b0; stall_in = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b0; imem_data = '0;
    @(negedge clk);
    test_reset();
    test_straight();
    test_wait_states();
    test_stall();
    test_branch_cancel();
    test_halt();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
